// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline types: fetch sequencer states and fetch constants.
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC and runs the imem req/ack handshake. It drives the IF/ID register inputs combinationally, for capture at the next edge.
// Memory waits become flush bubbles, hazards freeze IF/ID, and a branch that hits a pending request drains it before the target is fetched.
module fetch_ctrl
    import arm_pipe_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hazard,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_freeze,
    output logic        if_flush
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  hold_instr;
    logic [31:0]  drain_addr;
    logic [31:0]  pc_next_seq;

    assign pc_next_seq = pc + PC_STEP;

    // A request, once raised, is never withdrawn: DRAIN keeps presenting the abandoned address.
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_comb begin
        if_flush  = 1'b0;
        if_freeze = 1'b0;
        if_instr  = NOP_INSTR;
        if_pc     = pc;
        case (state)
            IDLE: if_flush = 1'b1;
            FETCH: begin
                if (branch_taken) begin
                    if_flush = 1'b1;
                end else if (hazard) begin
                    if_freeze = 1'b1;
                end else if (imem_ack) begin
                    if_instr = imem_rdata;
                    if_pc    = pc_next_seq;
                end else begin
                    if_flush = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    if_flush = 1'b1;
                end else if (hazard) begin
                    if_freeze = 1'b1;
                end else begin
                    if_instr = hold_instr;
                    if_pc    = pc_next_seq;
                end
            end
            DRAIN:   if_flush = 1'b1;
            default: if_flush = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= PC_RESET;
            hold_instr <= NOP_INSTR;
            drain_addr <= PC_RESET;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (branch_taken) begin
                        pc <= branch_addr;
                        if (!imem_ack) begin
                            drain_addr <= pc;
                            state      <= DRAIN;
                        end
                    end else if (hazard) begin
                        if (imem_ack) begin
                            hold_instr <= imem_rdata;
                            state      <= HOLD;
                        end
                    end else if (imem_ack) begin
                        pc <= pc_next_seq;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc    <= branch_addr;
                        state <= FETCH;
                    end else if (!hazard) begin
                        pc    <= pc_next_seq;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (branch_taken) begin
                        pc <= branch_addr;
                    end
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios, then random hazards/branches/waits checked against a program-order model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hazard;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_freeze;
    logic        if_flush;

    fetch_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_freeze    (if_freeze),
        .if_flush     (if_flush)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory model: fixed wait count, or random 0..3 when wait_cfg < 0.
    int   wait_cfg;
    logic mem_busy;
    int   wait_left;

    logic        s_req, s_frz, s_fl, s_ack;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hE3A0_1001;
    endfunction

    task automatic sample();
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_pc    = if_pc;
        s_instr = if_instr;
        s_frz   = if_freeze;
        s_fl    = if_flush;
        s_ack   = imem_ack;
    endtask

    task automatic step(input logic hz, input logic br, input logic [31:0] ba);
        @(posedge clk);
        #1;
        hazard       = hz;
        branch_taken = br;
        branch_addr  = ba;
        if (imem_req && !mem_busy) begin
            mem_busy  = 1'b1;
            wait_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        end
        imem_ack   = imem_req && mem_busy && (wait_left == 0);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        #1;
        sample();
        if (mem_busy) begin
            if (imem_ack) mem_busy = 1'b0;
            else          wait_left--;
        end
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        hazard       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        mem_busy     = 1'b0;
        wait_left    = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 sample();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        hazard = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        #3;
        sample();
        total++; if (s_req !== 1'b0)       begin bad++; $display("FAIL rst_req: got %0b want 0", s_req); end
        total++; if (s_fl !== 1'b1)        begin bad++; $display("FAIL rst_flush: got %0b want 1", s_fl); end
        total++; if (s_frz !== 1'b0)       begin bad++; $display("FAIL rst_freeze: got %0b want 0", s_frz); end
        total++; if (s_instr !== 32'h0)    begin bad++; $display("FAIL rst_instr: got %h want 0", s_instr); end
        total++; if (s_pc !== 32'h0)       begin bad++; $display("FAIL rst_pc: got %h want 0", s_pc); end
    endtask

    task automatic test_stream();
        wait_cfg = 0;
        do_reset();
        total++; if (s_fl !== 1'b1 || s_req !== 1'b0) begin bad++; $display("FAIL idle_cycle: got flush=%0b req=%0b want 1 0", s_fl, s_req); end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 32'h0);
            total++; if (s_addr !== 32'(k * 4)) begin bad++; $display("FAIL stream_addr%0d: got %h want %h", k, s_addr, k * 4); end
            total++; if (s_pc !== 32'(k * 4 + 4) || s_fl !== 1'b0) begin bad++; $display("FAIL stream_pc%0d: got %h flush=%0b want %h 0", k, s_pc, s_fl, k * 4 + 4); end
            total++; if (s_instr !== mem_word(32'(k * 4))) begin bad++; $display("FAIL stream_instr%0d: got %h want %h", k, s_instr, mem_word(32'(k * 4))); end
        end
    endtask

    task automatic test_wait();
        wait_cfg = 2;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 2; w++) begin
                step(1'b0, 1'b0, 32'h0);
                total++; if (s_fl !== 1'b1 || s_req !== 1'b1 || s_addr !== 32'(k * 4))
                    begin bad++; $display("FAIL wait_bubble%0d_%0d: got flush=%0b req=%0b addr=%h want 1 1 %h", k, w, s_fl, s_req, s_addr, k * 4); end
            end
            step(1'b0, 1'b0, 32'h0);
            total++; if (s_fl !== 1'b0 || s_addr !== 32'(k * 4) || s_pc !== 32'(k * 4 + 4))
                begin bad++; $display("FAIL wait_deliver%0d: got flush=%0b addr=%h pc=%h want 0 %h %h", k, s_fl, s_addr, s_pc, k * 4, k * 4 + 4); end
        end
    endtask

    task automatic test_hazard();
        wait_cfg = 0;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        total++; if (s_frz !== 1'b1 || s_fl !== 1'b0 || s_ack !== 1'b1) begin bad++; $display("FAIL hz_first: got freeze=%0b flush=%0b ack=%0b want 1 0 1", s_frz, s_fl, s_ack); end
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 1'b0, 32'h0);
            total++; if (s_frz !== 1'b1 || s_req !== 1'b0) begin bad++; $display("FAIL hz_hold%0d: got freeze=%0b req=%0b want 1 0", c, s_frz, s_req); end
        end
        step(1'b0, 1'b0, 32'h0);
        total++; if (s_frz !== 1'b0 || s_fl !== 1'b0 || s_instr !== mem_word(32'h4) || s_pc !== 32'h8 || s_req !== 1'b0)
            begin bad++; $display("FAIL hz_resume: got frz=%0b fl=%0b instr=%h pc=%h req=%0b want 0 0 %h 8 0", s_frz, s_fl, s_instr, s_pc, s_req, mem_word(32'h4)); end
        step(1'b0, 1'b0, 32'h0);
        total++; if (s_req !== 1'b1 || s_addr !== 32'h8) begin bad++; $display("FAIL hz_next_addr: got req=%0b addr=%h want 1 8", s_req, s_addr); end
    endtask

    task automatic test_branch_drain();
        wait_cfg = 3;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h100);
        total++; if (s_fl !== 1'b1 || s_frz !== 1'b0) begin bad++; $display("FAIL br_flush: got flush=%0b freeze=%0b want 1 0", s_fl, s_frz); end
        step(1'b0, 1'b0, 32'h0);
        total++; if (s_req !== 1'b1 || s_addr !== 32'h0 || s_fl !== 1'b1) begin bad++; $display("FAIL drain_wait: got req=%0b addr=%h flush=%0b want 1 0 1", s_req, s_addr, s_fl); end
        step(1'b0, 1'b0, 32'h0);
        total++; if (s_ack !== 1'b1 || s_addr !== 32'h0 || s_fl !== 1'b1) begin bad++; $display("FAIL drain_discard: got ack=%0b addr=%h flush=%0b want 1 0 1", s_ack, s_addr, s_fl); end
        step(1'b0, 1'b0, 32'h0);
        total++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin bad++; $display("FAIL drain_target: got req=%0b addr=%h want 1 100", s_req, s_addr); end
    endtask

    task automatic test_branch_hazard();
        wait_cfg = 0;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h200);
        total++; if (s_fl !== 1'b1 || s_frz !== 1'b0) begin bad++; $display("FAIL br_over_hz: got flush=%0b freeze=%0b want 1 0", s_fl, s_frz); end
        step(1'b0, 1'b0, 32'h0);
        total++; if (s_addr !== 32'h200 || s_pc !== 32'h204) begin bad++; $display("FAIL br_target: got addr=%h pc=%h want 200 204", s_addr, s_pc); end
    endtask

    task automatic test_wrap();
        wait_cfg = 0;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        total++; if (s_addr !== 32'hFFFF_FFFC || s_pc !== 32'h0 || s_instr !== mem_word(32'hFFFF_FFFC))
            begin bad++; $display("FAIL wrap_deliver: got addr=%h pc=%h instr=%h want fffffffc 0 %h", s_addr, s_pc, s_instr, mem_word(32'hFFFF_FFFC)); end
        step(1'b0, 1'b0, 32'h0);
        total++; if (s_addr !== 32'h0) begin bad++; $display("FAIL wrap_next: got addr=%h want 0", s_addr); end
    endtask

    task automatic test_reset_mid_drain();
        wait_cfg = 3;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 32'h0);
        total++; if (s_req !== 1'b1 || s_fl !== 1'b1) begin bad++; $display("FAIL pre_reset_drain: got req=%0b flush=%0b want 1 1", s_req, s_fl); end
        #2 reset_n = 1'b0;
        #1 sample();
        total++; if (s_req !== 1'b0 || s_fl !== 1'b1 || s_frz !== 1'b0 || s_instr !== 32'h0 || s_pc !== 32'h0)
            begin bad++; $display("FAIL async_reset: got req=%0b fl=%0b frz=%0b instr=%h pc=%h want 0 1 0 0 0", s_req, s_fl, s_frz, s_instr, s_pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic        hz, br, delivered;
        logic [31:0] ba;
        logic        prev_req, prev_ack;
        logic [31:0] prev_addr;
        int          deliveries;
        wait_cfg   = -1;
        do_reset();
        exp_pc     = 32'h0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_addr  = 32'h0;
        deliveries = 0;
        for (int n = 0; n < 2000; n++) begin
            hz = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 7) == 0);
            ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step(hz, br, ba);
            delivered = !s_frz && !s_fl;
            total++; if (s_frz && s_fl) begin bad++; $display("FAIL rnd_exclusive@%0d: got freeze=1 flush=1", n); end
            if (prev_req && !prev_ack) begin
                total++; if (s_req !== 1'b1 || s_addr !== prev_addr)
                    begin bad++; $display("FAIL rnd_handshake@%0d: got req=%0b addr=%h want 1 %h", n, s_req, s_addr, prev_addr); end
            end
            if (br) begin
                total++; if (s_fl !== 1'b1 || s_frz !== 1'b0) begin bad++; $display("FAIL rnd_branch@%0d: got flush=%0b freeze=%0b want 1 0", n, s_fl, s_frz); end
                exp_pc = ba;
            end else begin
                if (hz) begin
                    total++; if (delivered) begin bad++; $display("FAIL rnd_hazard@%0d: got delivery want hold/bubble", n); end
                end
                if (delivered) begin
                    total++; if (s_pc !== exp_pc + 32'd4 || s_instr !== mem_word(exp_pc))
                        begin bad++; $display("FAIL rnd_deliver@%0d: got pc=%h instr=%h want %h %h", n, s_pc, s_instr, exp_pc + 32'd4, mem_word(exp_pc)); end
                    exp_pc = exp_pc + 32'd4;
                    deliveries++;
                end
            end
            prev_req  = s_req;
            prev_ack  = s_ack;
            prev_addr = s_addr;
        end
        total++; if (deliveries < 100) begin bad++; $display("FAIL rnd_progress: got %0d deliveries want >=100", deliveries); end
    endtask

    initial begin
        mem_busy  = 1'b0;
        wait_left = 0;
        wait_cfg  = 0;
        test_reset();
        test_stream();
        test_wait();
        test_hazard();
        test_branch_drain();
        test_branch_hazard();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the 5-stage ARM pipeline. Owns the program counter, runs the instruction-memory request/acknowledge handshake, and drives the `freeze`/`flush` controls and data inputs of the IF/ID pipeline register. It absorbs variable memory latency, hazard stalls and taken branches, so the IF/ID register only ever captures a valid instruction, holds, or loads a bubble.

## Interface
- `PC_RESET`, 32'h0000_0000, first fetch address after reset
- `PC_STEP`, 4, PC increment per delivered instruction
- `clk`  in  1  pipeline clock
- `reset_n`  in  1  asynchronous, active-low reset
- `hazard`  in  1  ID-stage stall request; IF/ID must hold
- `branch_taken`  in  1  taken branch resolved in EXE
- `branch_addr`  in  32  branch target
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address
- `imem_ack`  in  1  response valid; may arrive in the same cycle as `imem_req`
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`
- `if_pc`  out  32  address of the delivered instruction + `PC_STEP`; feeds the IF/ID `PC_in`
- `if_instr`  out  32  instruction word; feeds the IF/ID `Instruction_in`
- `if_freeze`  out  1  to IF/ID `freeze`
- `if_flush`  out  1  to IF/ID `flush`

## Operation
- **Registers**
  - `pc`: 32-bit fetch address.
  - `hold_instr`: 32-bit buffered instruction.
  - `state`: one of IDLE, FETCH, HOLD, DRAIN.
- **Reset** (asynchronous, `reset_n` low)
  - `state` = IDLE, `pc` = `PC_RESET`, `hold_instr` = 0.
  - Outputs while in reset: `imem_req`=0, `if_flush`=1, `if_freeze`=0, `if_instr`=0, `if_pc`=`PC_RESET`.
- **IDLE**
  - `imem_req`=0, `if_flush`=1.
  - Always moves to FETCH on the next clock.
- **FETCH**
  - `imem_req`=1, `imem_addr`=`pc`.
  - Evaluate in this priority order:
    1. `branch_taken` with `imem_ack`: discard `imem_rdata`. `pc` <= `branch_addr`, `if_flush`=1, stay in FETCH.
    2. `branch_taken` without `imem_ack`: `pc` <= `branch_addr`, `if_flush`=1, go to DRAIN.
    3. `hazard` with `imem_ack`: `hold_instr` <= `imem_rdata`, `if_freeze`=1, go to HOLD.
    4. `hazard` without `imem_ack`: `if_freeze`=1, stay in FETCH.
    5. `imem_ack`: `if_instr`=`imem_rdata`, `if_pc`=`pc`+`PC_STEP`, freeze=flush=0. `pc` <= `pc`+`PC_STEP`, stay in FETCH.
    6. No `imem_ack`: `if_flush`=1 (bubble), stay in FETCH.
- **HOLD**
  - `imem_req`=0.
  - `branch_taken`: `pc` <= `branch_addr`, `if_flush`=1, go to FETCH. `hold_instr` is dropped.
  - Else `hazard`: `if_freeze`=1, stay in HOLD.
  - Else: deliver `hold_instr` with `if_pc`=`pc`+`PC_STEP`. `pc` <= `pc`+`PC_STEP`, go to FETCH.
- **DRAIN**
  - `imem_req`=1, `imem_addr` = the address of the abandoned request, held in `drain_addr`.
  - `if_flush`=1.
  - On `imem_ack`: discard the data, go to FETCH.
  - A further `branch_taken` while in DRAIN updates `pc` only.
- **Invariants**
  - `if_freeze` and `if_flush` are never both 1.
  - `branch_taken` always overrides `hazard`.
- **Arithmetic**: all PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. No alignment check.

## Timing
- `imem_req`/`imem_addr` are Moore outputs (from state and registers). `if_*` outputs are combinational from state and the current inputs. IF/ID captures them at the next edge.
- **Handshake**: once `imem_req` is raised, `imem_req` and `imem_addr` stay stable until the cycle `imem_ack`=1. A request is never withdrawn; this is why DRAIN exists.
- **Throughput**: zero-wait memory (ack in the same cycle as req) gives 1 instruction per cycle. N wait cycles give N bubbles per instruction.
- **Branch penalty** (zero-wait memory): 1 flushed IF slot. The target is requested in the cycle after `branch_taken`.
- **Resume after hazard**: when `hazard` deasserts in HOLD, the buffered instruction is delivered in the same cycle. No refetch.
- **Reset mid-operation**: an outstanding memory request is abandoned. The memory model must tolerate this.

## Structure
- A shared package `arm_pipe_pkg` holds:
  - the `fetch_state_t` enum (IDLE, FETCH, HOLD, DRAIN);
  - `PC_STEP_DEFAULT`;
  - `NOP_INSTR` = 32'h0.
- Single module with no sub-module. `hold_instr`, `pc` and `drain_addr` are local registers.

## Test plan
1. Reset release, zero-wait memory returning 32'hE3A0_1001 at 0, then further words: `imem_addr` = 0, 4, 8 in consecutive cycles; `if_pc` = 4, 8, 12; `if_flush`=1 in the IDLE cycle only.
2. Memory with 2 wait cycles: each instruction is preceded by exactly 2 cycles of `if_flush`=1. The address stays stable throughout every wait.
3. `hazard` high for 3 cycles with ack in the first: state goes to HOLD, `if_freeze`=1 for 3 cycles, `imem_req`=0. The held word is delivered in the cycle `hazard` drops; the next address is `pc`+4.
4. `branch_taken` with `branch_addr`=32'h100 while a 3-wait fetch is pending: `if_flush` stays high through DRAIN, the stale data is discarded, and the next request is to 32'h100.
5. `branch_taken` and `hazard` both high in FETCH: the flush wins and `if_freeze` stays 0.
6. `pc`=32'hFFFF_FFFC delivers its instruction: the next `imem_addr` is 0. Separately, assert `reset_n` low mid-DRAIN: all reset values appear immediately, without waiting for a clock edge.
